// File: rtl/skolem_pkg.sv
// Shared types for the sequential bvneg Skolem witness search.
package skolem_pkg;

  typedef enum logic [1:0] {
    OP_ULE = 2'd0,
    OP_ULT = 2'd1,
    OP_UGE = 2'd2,
    OP_UGT = 2'd3
  } cmp_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } fsm_e;

endpackage

// File: rtl/skolem_inv_bvneg_cmp_seq_if.sv
// Request/response handshake bundle for skolem_inv_bvneg_cmp_seq.
// out_timeout exists only when SKOLEM_TIMEOUT_EN is defined.
interface skolem_inv_bvneg_cmp_seq_if #(
  parameter int W = 4
) ();
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_t;
  logic [W-1:0] in_lo;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_x;
  logic         out_sat;
  logic [W:0]   out_iters;
`ifdef SKOLEM_TIMEOUT_EN
  logic         out_timeout;
`endif

  modport master (
    output in_valid, in_op, in_t, in_lo, out_ready,
    input  in_ready, out_valid, out_x, out_sat, out_iters
`ifdef SKOLEM_TIMEOUT_EN
    , input out_timeout
`endif
  );

  modport slave (
    input  in_valid, in_op, in_t, in_lo, out_ready,
    output in_ready, out_valid, out_x, out_sat, out_iters
`ifdef SKOLEM_TIMEOUT_EN
    , output out_timeout
`endif
  );
endinterface

// File: rtl/neg_cmp_pred.sv
// Combinational predicate cmp(bvneg(cand), t), unsigned compare.
module neg_cmp_pred
  import skolem_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_cand,
  input  logic [W-1:0] i_t,
  input  cmp_op_e      i_op,
  output logic         o_pred
);
  logic [W-1:0] w_neg;

  always_comb begin
    w_neg = ~i_cand + 1'b1;
    o_pred = 1'b0;
    unique case (i_op)
      OP_ULE:  o_pred = (w_neg <= i_t);
      OP_ULT:  o_pred = (w_neg <  i_t);
      OP_UGE:  o_pred = (w_neg >= i_t);
      OP_UGT:  o_pred = (w_neg >  i_t);
      default: o_pred = 1'b0;
    endcase
  end
endmodule

// File: rtl/skolem_inv_bvneg_cmp_seq.sv
// Linear search for the smallest x >= lo with cmp(-x, t); one evaluation per cycle.
// Optional evaluation cap enabled by defining SKOLEM_TIMEOUT_EN.
module skolem_inv_bvneg_cmp_seq
  import skolem_pkg::*;
#(
  parameter int W        = 4,
  parameter int MAX_ITER = 2**W
) (
  input  logic                        clk,
  input  logic                        rst,
  skolem_inv_bvneg_cmp_seq_if.slave   bus
);
  fsm_e         r_state;
  cmp_op_e      r_op;
  logic [W-1:0] r_t;
  logic [W-1:0] r_cand;
  logic [W:0]   r_iters;
  logic [W-1:0] r_x;
  logic         r_sat;
  logic         r_in_ready;
  logic         r_out_valid;
`ifdef SKOLEM_TIMEOUT_EN
  localparam logic [W:0] ITER_CAP = (W+1)'(MAX_ITER);
  logic         r_timeout;
`endif

  logic         w_pred;
  logic         w_last;
  logic [W:0]   w_iters_nxt;

  neg_cmp_pred #(.W(W)) u_pred (
    .i_cand (r_cand),
    .i_t    (r_t),
    .i_op   (r_op),
    .o_pred (w_pred)
  );

  assign w_last      = (r_cand == '1);
  assign w_iters_nxt = r_iters + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_ULE;
      r_t         <= '0;
      r_cand      <= '0;
      r_iters     <= '0;
      r_x         <= '0;
      r_sat       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef SKOLEM_TIMEOUT_EN
      r_timeout   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_op       <= cmp_op_e'(bus.in_op);
            r_t        <= bus.in_t;
            r_cand     <= bus.in_lo;
            r_iters    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          r_iters <= w_iters_nxt;
          // Witness wins over exhaustion, exhaustion over the cap.
          if (w_pred) begin
            r_x         <= r_cand;
            r_sat       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef SKOLEM_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
          end else if (w_last) begin
            r_x         <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef SKOLEM_TIMEOUT_EN
            r_timeout   <= 1'b0;
          end else if (w_iters_nxt == ITER_CAP) begin
            r_x         <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b1;
            r_timeout   <= 1'b1;
            r_state     <= S_DONE;
`endif
          end else begin
            r_cand <= r_cand + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_x     = r_x;
  assign bus.out_sat   = r_sat;
  assign bus.out_iters = r_iters;
`ifdef SKOLEM_TIMEOUT_EN
  assign bus.out_timeout = r_timeout;
`endif
endmodule

// File: doc/skolem_inv_bvneg_cmp_seq.md
Name: skolem_inv_bvneg_cmp_seq

Overview:
- Sequential, parametrised successor to the fixed 4-bit combinational Skolem witness generators for bvneg inverse conditions.
- Finds the smallest unsigned x, with LO <= x <= 2^W-1, such that cmp(bvneg(x), t) holds, where cmp is one of ule/ult/uge/ugt, selected per request.
- Reports whether a witness exists.
- Sits behind the invertibility-condition front end; request/response use valid/ready handshakes.

Parameters:
- W, 4, operand width in bits (W >= 2).
- MAX_ITER, 2**W, evaluation cap. Used only when SKOLEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_op  in  2  0=ule, 1=ult, 2=uge, 3=ugt, applied as (-x) op t
- in_t  in  W  comparison bound t
- in_lo  in  W  lower bound on the witness x
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_x  out  W  witness; 0 when unsat
- out_sat  out  1  1 = witness found
- out_iters  out  W+1  number of predicate evaluations performed
- out_timeout  out  1  only when SKOLEM_TIMEOUT_EN is defined

Behaviour:
- Reset: one clock and one reset. The reset is synchronous and active-high.
  - State returns to IDLE.
  - in_ready=1; out_valid=0, out_x=0, out_sat=0, out_iters=0, out_timeout=0.
  - All request registers are cleared.
  - Reset mid-SEARCH or mid-DONE aborts the request and emits no response.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On a handshake: latch op, t, lo; cand<=lo; iters<=0; go to SEARCH.
- SEARCH:
  - in_ready=0.
  - Each cycle: neg = (~cand + 1) mod 2^W; evaluate pred(neg, t) as an unsigned compare; iters<=iters+1.
  - pred true -> out_x<=cand, out_sat<=1, go to DONE.
  - pred false and cand == 2^W-1 -> out_x<=0, out_sat<=0, go to DONE. No wrap-around past all-ones.
  - Otherwise cand<=cand+1.
- DONE:
  - out_valid=1; out_x, out_sat, out_iters are stable until out_ready.
  - On out_ready: go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
- Latency: out_valid rises (x-lo)+2 cycles after the accept edge; out_iters = x-lo+1.
- Worst-case unsat latency: 2^W-lo+1 cycles, with out_iters = 2^W-lo.
- bvneg(0)=0. Width W+1 on out_iters covers lo=0 unsat (2^W evaluations).
- Inputs are ignored outside IDLE. out_ready is ignored outside DONE.

Optional Feature:
- Macro: SKOLEM_TIMEOUT_EN.
- Defined:
  - SEARCH also terminates when iters+1 == MAX_ITER with pred false.
  - Result: out_sat=0, out_x=0, out_timeout=1.
  - A found witness or an exhausted range gives out_timeout=0.
- Undefined:
  - The out_timeout port and its logic are absent.
  - Search always runs to a witness or to all-ones.

Decomposition:
- Package skolem_pkg holds:
  - enum cmp_op_e {OP_ULE, OP_ULT, OP_UGE, OP_UGT}
  - enum fsm_e {S_IDLE, S_SEARCH, S_DONE}
- One natural combinational sub-module, neg_cmp_pred (W-parameterised): inputs cand, t, op; output pred.
  - Shared with the combinational witness checker used in verification.

Test Plan (W=4):
- op=ule, t=3, lo=0 -> out_x=0, sat=1, iters=1; out_valid 2 cycles after accept.
- op=ule, t=3, lo=1 -> candidates x=1..12 give -x=15..4, all fail; x=13 gives -x=3 -> out_x=13, sat=1, iters=13, latency 14 cycles.
- op=ult, t=0, lo=0 and op=ugt, t=15, lo=0 -> sat=0, out_x=0, iters=16, latency 17 cycles.
- op=uge, t=5, lo=0 -> out_x=1 (-1=15 >= 5), iters=2.
- Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0; release -> IDLE, in_ready=1 next cycle. Assert rst during SEARCH -> all outputs return to their reset values next cycle and no response is emitted.
- With SKOLEM_TIMEOUT_EN and MAX_ITER=4: op=ule, t=3, lo=1 -> out_timeout=1, sat=0, iters=4.
